neuron_out_packetizer: RTL and testbench
========================================

Name: neuron_out_packetizer

Overview:
- Sits directly downstream of a neuron processing element, between the neuron and its router port.
- Accepts 8-bit activation results, buffers them, and emits one 16-bit NoC packet per successor neuron.
- Each packet has the format {data[15:8], src_x[7:6], src_y[5:4], dst_x[3:2], dst_y[1:0]}.
- Uses a valid/ready handshake to the switch, replacing ad-hoc sequential output of multiple destination packets.

Parameters:
- X_COORD, 2'b01, own switch x address (packet bits [7:6])
- Y_COORD, 2'b00, own switch y address (packet bits [5:4])
- NUM_DEST, 2, number of successor destinations, legal range 1..4
- DEST_LIST, 16'h0098, packed destination table; entry i = bits [4i+3:4i] = {dst_x, dst_y}; default entry0 = (2,0), entry1 = (2,1)
- FIFO_DEPTH, 4, activation buffer depth, power of two, 2..16

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- act_in  in  8  activation value from the neuron
- act_valid  in  1  act_in is valid this cycle
- act_ready  out  1  buffer can accept act_in
- pkt_out  out  16  packet to the switch
- pkt_valid  out  1  pkt_out is valid
- pkt_ready  in  1  switch accepts pkt_out this cycle
- busy  out  1  FIFO non-empty or packet pending
- sent_count  out  8  total packets accepted by the switch since reset; wraps 255->0

Behaviour:
- Reset (rst=1 at an edge):
  - pkt_out=0, pkt_valid=0, sent_count=0, busy=0.
  - FIFO emptied, FSM to IDLE, dest_idx=0.
  - act_ready=0 while rst is high.
  - Reset mid-transmission discards the pending packet and all buffered activations, with no further packets.
- Input side:
  - Accept when act_valid & act_ready at an edge; act_in is written to the FIFO.
  - act_ready = !rst & (count != FIFO_DEPTH), combinational from registered count.
  - When full, a push is refused even if a pop occurs in the same cycle. No data is ever dropped silently.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
- FSM states: IDLE, SEND.
  - IDLE: if FIFO non-empty, pop the head into act_reg, set dest_idx=0, load pkt_out={head, X_COORD, Y_COORD, DEST_LIST[3:0]}, set pkt_valid=1, go to SEND. Otherwise stay with pkt_valid=0.
  - SEND: pkt_out and pkt_valid are held stable until pkt_ready=1.
  - On a handshake (pkt_valid & pkt_ready at an edge), sent_count increments.
    - If dest_idx < NUM_DEST-1: dest_idx+1; pkt_out={act_reg, X_COORD, Y_COORD, DEST_LIST[entry dest_idx+1]}; stay in SEND (pkt_valid remains 1).
    - Else if FIFO non-empty: pop the next activation, dest_idx=0, load its first packet; stay in SEND (back-to-back, no bubble).
    - Else: pkt_valid=0, go to IDLE.
- Latency: an activation accepted at edge N into an empty, idle block has pkt_valid=1 after edge N+1. Successive destinations of the same activation, and packets of following activations, are issued at 1 packet per cycle under continuous pkt_ready.
- Ordering:
  - Activations leave in acceptance order.
  - For each activation, destinations are issued in DEST_LIST index order 0..NUM_DEST-1.
  - Destinations are never interleaved across activations.
- busy = (count != 0) | pkt_valid, registered-equivalent (derived from registers only).
- The data field is passed unmodified; no sign or width conversion.
- NUM_DEST=1: every activation yields exactly one packet, to entry0.

Test Plan:
- Single activation, pkt_ready=1, defaults: act_in=8'h3C at edge N -> pkt_out=16'h3C48 after N+1, 16'h3C49 after N+2; pkt_valid low after N+3; sent_count=2.
- Backpressure: pkt_ready=0 for 5 cycles after first packet -> pkt_out held at 16'h3C48 and pkt_valid=1 throughout; after release, 16'h3C49 follows next cycle.
- Fill: pkt_ready=0, push 5 activations back-to-back -> 1 packet loaded plus 4 buffered; act_ready=0 on the 6th attempt; on release, all 10 packets emerge in order.
- Back-to-back: 3 activations A1,A2,A3 with pkt_ready=1 -> 6 consecutive cycles of pkt_valid=1 with no bubble; sent_count=6.
- Reset mid-operation: rst=1 while pkt_valid=1 with 2 activations buffered -> next cycle pkt_valid=0, busy=0, sent_count=0, act_ready=0; after rst drops, no stale packets appear.
- Wrap: 128 activations with NUM_DEST=2 -> sent_count returns to 0.

Source files
------------

// File: rtl/neuron_out_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_out_packetizer
//  Description : Buffers 8-bit neuron activations in a small FIFO and emits
//                one 16-bit NoC packet per successor destination over a
//                valid/ready handshake to the router port.
//                Packet = {data[15:8], src_x[7:6], src_y[5:4],
//                          dst_x[3:2], dst_y[1:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_out_packetizer #(
    parameter logic [1:0]  X_COORD    = 2'b01,
    parameter logic [1:0]  Y_COORD    = 2'b00,
    parameter int          NUM_DEST   = 2,
    parameter logic [15:0] DEST_LIST  = 16'h0098,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  act_in,
    input  logic        act_valid,
    output logic        act_ready,
    output logic [15:0] pkt_out,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        busy,
    output logic [7:0]  sent_count
);

    localparam int            C_AW       = $clog2(FIFO_DEPTH);
    localparam int            C_CW       = C_AW + 1;
    localparam logic [C_CW-1:0] C_DEPTH  = C_CW'(FIFO_DEPTH);
    localparam logic [1:0]    C_LAST_IDX = 2'(NUM_DEST - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [C_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_CW-1:0]   count_q, count_d;
    logic [1:0]        dest_idx_q, dest_idx_d;
    logic [7:0]        act_reg_q, act_reg_d;
    logic [15:0]       pkt_out_q, pkt_out_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [7:0]        sent_count_q, sent_count_d;

    logic              w_push;
    logic              w_pop;
    logic              w_fifo_nonempty;
    logic [7:0]        w_head;
    logic [1:0]        w_next_idx;
    logic [3:0]        w_next_dest;

    // Input handshake: readiness depends only on registered occupancy, so a
    // same-cycle pop never lets a push into a full buffer.
    assign act_ready       = !rst && (count_q != C_DEPTH);
    assign w_push          = act_valid && act_ready;
    assign w_fifo_nonempty = (count_q != '0);
    assign w_head          = fifo_mem[rd_ptr_q];
    assign w_next_idx      = dest_idx_q + 2'd1;
    assign w_next_dest     = DEST_LIST[{w_next_idx, 2'b00} +: 4];

    assign pkt_out    = pkt_out_q;
    assign pkt_valid  = pkt_valid_q;
    assign sent_count = sent_count_q;
    assign busy       = w_fifo_nonempty || pkt_valid_q;

    // Packet sequencer: walks the destination table per activation and pulls
    // the next activation on the final handshake so streams have no bubble.
    always_comb begin
        state_d      = state_q;
        dest_idx_d   = dest_idx_q;
        act_reg_d    = act_reg_q;
        pkt_out_d    = pkt_out_q;
        pkt_valid_d  = pkt_valid_q;
        sent_count_d = sent_count_q;
        w_pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop       = 1'b1;
                    act_reg_d   = w_head;
                    dest_idx_d  = 2'd0;
                    pkt_out_d   = {w_head, X_COORD, Y_COORD, DEST_LIST[3:0]};
                    pkt_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (pkt_ready) begin
                    sent_count_d = sent_count_q + 8'd1;
                    if (dest_idx_q != C_LAST_IDX) begin
                        dest_idx_d = w_next_idx;
                        pkt_out_d  = {act_reg_q, X_COORD, Y_COORD, w_next_dest};
                    end else if (w_fifo_nonempty) begin
                        w_pop      = 1'b1;
                        act_reg_d  = w_head;
                        dest_idx_d = 2'd0;
                        pkt_out_d  = {w_head, X_COORD, Y_COORD, DEST_LIST[3:0]};
                    end else begin
                        pkt_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                pkt_valid_d = 1'b0;
            end
        endcase
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Activation storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= act_in;
        end
    end

    // State register with synchronous reset discarding all pending work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dest_idx_q   <= 2'd0;
            act_reg_q    <= 8'd0;
            pkt_out_q    <= 16'd0;
            pkt_valid_q  <= 1'b0;
            sent_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dest_idx_q   <= dest_idx_d;
            act_reg_q    <= act_reg_d;
            pkt_out_q    <= pkt_out_d;
            pkt_valid_q  <= pkt_valid_d;
            sent_count_q <= sent_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_out_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_out_packetizer
//  Description : Directed self-checking bench with a packet scoreboard for
//                neuron_out_packetizer (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
`define CHK(TAG, OBS, EXP) \
    begin \
        n_vec++; \
        assert ((OBS) === (EXP)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

module tb_neuron_out_packetizer;

    localparam logic [3:0] C_DEST0 = 4'h8;   // (x=2, y=0)
    localparam logic [3:0] C_DEST1 = 4'h9;   // (x=2, y=1)

    logic        clk;
    logic        rst;
    logic [7:0]  act_in;
    logic        act_valid;
    logic        act_ready;
    logic [15:0] pkt_out;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        busy;
    logic [7:0]  sent_count;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_q[$];
    logic [15:0] exp_pkt;
    logic [7:0]  exp_sent;
    int          run_len;
    logic        seen_valid;

    neuron_out_packetizer dut (
        .clk        (clk),
        .rst        (rst),
        .act_in     (act_in),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .pkt_out    (pkt_out),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .busy       (busy),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk_pkt(input logic [7:0] a, input logic [3:0] d);
        return {a, 2'b01, 2'b00, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one activation for one cycle; the bench states whether it must be taken.
    task automatic push_act(input logic [7:0] a, input logic exp_rdy);
        act_in    = a;
        act_valid = 1'b1;
        `CHK("act_ready", act_ready, exp_rdy)
        if (exp_rdy) begin
            exp_q.push_back(mk_pkt(a, C_DEST0));
            exp_q.push_back(mk_pkt(a, C_DEST1));
        end
        tick();
        act_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy) break;
            tick();
        end
        `CHK("drain_busy", busy, 1'b0)
    endtask

    // Scoreboard: every handshake seen ahead of the next edge is checked.
    always @(negedge clk) begin
        if (!rst && pkt_valid && pkt_ready) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_pkt: observed %0h expected none", pkt_out);
            end
            if (exp_q.size() != 0) begin
                exp_pkt = exp_q.pop_front();
                `CHK("sb_pkt", pkt_out, exp_pkt)
            end
            exp_sent = exp_sent + 8'd1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_sent  = 8'd0;
        rst       = 1'b1;
        act_in    = 8'd0;
        act_valid = 1'b0;
        pkt_ready = 1'b0;

        // Reset state
        tick();
        tick();
        `CHK("rst_pkt_valid", pkt_valid, 1'b0)
        `CHK("rst_pkt_out", pkt_out, 16'h0000)
        `CHK("rst_sent", sent_count, 8'd0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_act_ready", act_ready, 1'b0)
        rst = 1'b0;
        #1;
        `CHK("post_rst_act_ready", act_ready, 1'b1)

        // Single activation, free-flowing output
        pkt_ready = 1'b1;
        push_act(8'h3C, 1'b1);
        `CHK("t1_valid_n", pkt_valid, 1'b0)
        `CHK("t1_busy_n", busy, 1'b1)
        tick();
        `CHK("t1_valid_n1", pkt_valid, 1'b1)
        `CHK("t1_pkt_n1", pkt_out, 16'h3C48)
        tick();
        `CHK("t1_pkt_n2", pkt_out, 16'h3C49)
        tick();
        `CHK("t1_valid_n3", pkt_valid, 1'b0)
        `CHK("t1_sent", sent_count, 8'd2)
        `CHK("t1_busy_end", busy, 1'b0)

        // Backpressure holds the packet stable
        pkt_ready = 1'b0;
        push_act(8'hA5, 1'b1);
        tick();
        `CHK("t2_first", pkt_out, 16'hA548)
        for (int i = 0; i < 5; i++) begin
            tick();
            `CHK("t2_hold_valid", pkt_valid, 1'b1)
            `CHK("t2_hold_pkt", pkt_out, 16'hA548)
        end
        pkt_ready = 1'b1;
        tick();
        `CHK("t2_second", pkt_out, 16'hA549)
        `CHK("t2_second_valid", pkt_valid, 1'b1)
        tick();
        `CHK("t2_done_valid", pkt_valid, 1'b0)
        `CHK("t2_sent", sent_count, exp_sent)

        // Fill: one packet loaded plus a full buffer, then refusal
        pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_act(8'h10 + 8'(i), 1'b1);
        end
        push_act(8'h15, 1'b0);
        pkt_ready = 1'b1;
        wait_idle(40);
        `CHK("t3_sb_empty", exp_q.size(), 0)
        `CHK("t3_sent", sent_count, exp_sent)

        // Back-to-back: 3 activations give 6 bubble-free packets
        run_len = 0;
        push_act(8'hA1, 1'b1);
        push_act(8'hA2, 1'b1);
        if (pkt_valid) run_len++;
        push_act(8'hA3, 1'b1);
        if (pkt_valid) run_len++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!pkt_valid) break;
            run_len++;
        end
        `CHK("t4_run_len", run_len, 6)
        `CHK("t4_sent", sent_count, exp_sent)
        `CHK("t4_sb_empty", exp_q.size(), 0)

        // Reset mid-transmission with two activations buffered
        pkt_ready = 1'b0;
        push_act(8'hB0, 1'b1);
        push_act(8'hB1, 1'b1);
        push_act(8'hB2, 1'b1);
        `CHK("t5_pre_valid", pkt_valid, 1'b1)
        rst = 1'b1;
        exp_q.delete();
        tick();
        exp_sent = 8'd0;
        `CHK("t5_valid", pkt_valid, 1'b0)
        `CHK("t5_busy", busy, 1'b0)
        `CHK("t5_sent", sent_count, 8'd0)
        `CHK("t5_act_ready", act_ready, 1'b0)
        `CHK("t5_pkt_out", pkt_out, 16'h0000)
        rst = 1'b0;
        pkt_ready = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pkt_valid) seen_valid = 1'b1;
        end
        `CHK("t5_no_stale", seen_valid, 1'b0)

        // Wrap: 128 activations x 2 destinations = 256 packets
        for (int i = 0; i < 128; i++) begin
            push_act(8'(i) + 8'h40, 1'b1);
            tick();
        end
        wait_idle(40);
        `CHK("t6_sb_empty", exp_q.size(), 0)
        `CHK("t6_wrap_model", sent_count, exp_sent)
        `CHK("t6_wrap_zero", sent_count, 8'd0)

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
